// File: rtl/add_accum16_pkg.sv
// Shared types and widths for the add_accum16 streaming accumulator.
package add_accum16_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_t;

endpackage

// File: rtl/add_accum16_adder16.sv
// Existing combinational 16-bit adder datapath: z = x + y, carry = bit 16.
import add_accum16_pkg::*;

module adder16 (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] z,
    output logic              carry
);

    assign {carry, z} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/add_accum16.sv
// Packet accumulator: sums a valid/ready stream of 16-bit operands modulo 2^16,
// counts carry-outs (saturating) and emits one result beat per packet.
import add_accum16_pkg::*;

module add_accum16 #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_carries
);

    acc_state_t        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_d, out_valid_d;
    logic [DATA_W-1:0] out_sum_d;
    logic [CNT_W-1:0]  out_carries_d;

    logic [DATA_W-1:0] add_x, add_z;
    logic              add_carry;
    logic [CNT_W-1:0]  cnt_base, cnt_next;
    logic [CNT_W:0]    cnt_sum;
    logic              beat;

    // A fresh packet starts from zero without waiting for acc to be cleared.
    assign add_x = (state_q == IDLE) ? '0 : acc_q;

    adder16 u_adder (
        .x     (add_x),
        .y     (in_data),
        .z     (add_z),
        .carry (add_carry)
    );

    assign cnt_base = (state_q == IDLE) ? '0 : cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(add_carry);
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign beat     = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        in_ready_d    = in_ready;
        out_valid_d   = out_valid;
        out_sum_d     = out_sum;
        out_carries_d = out_carries;
        case (state_q)
            IDLE, ACCUM: begin
                in_ready_d = 1'b1;
                if (beat) begin
                    if (in_last) begin
                        out_sum_d     = add_z;
                        out_carries_d = cnt_next;
                        out_valid_d   = 1'b1;
                        in_ready_d    = 1'b0;
                        state_d       = HOLD;
                    end else begin
                        acc_d   = add_z;
                        cnt_d   = cnt_next;
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_carries <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            out_sum     <= out_sum_d;
            out_carries <= out_carries_d;
        end
    end

endmodule

// File: tb/tb_add_accum16.sv
// Directed bench for add_accum16; a CNT_W=2 copy shares the stimulus to exercise saturation.
module tb_add_accum16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid;
    logic [15:0] out_sum;
    logic [7:0]  out_carries;

    logic        in_ready2, out_valid2;
    logic [15:0] out_sum2;
    logic [1:0]  out_carries2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    add_accum16 #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carries(out_carries)
    );

    add_accum16 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_carries(out_carries2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one beat at a negedge and returns at the negedge after it is accepted.
    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_carries", {24'd0, out_carries}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

        // 8fff + 8000 + 0001 -> 1000, one carry
        send(16'h8fff, 1'b0);
        send(16'h8000, 1'b0);
        check("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
        send(16'h0001, 1'b1);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_sum", {16'd0, out_sum}, 32'h1000);
        check("t1_carries", {24'd0, out_carries}, 32'd1);
        check("t1_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("t1_valid_one_cycle", {31'd0, out_valid}, 32'd0);
        check("t1_in_ready_back", {31'd0, in_ready}, 32'd1);
        check("t1_sum_kept", {16'd0, out_sum}, 32'h1000);

        // Single-beat packet, then backpressure with a pending 1234 beat
        out_ready = 1'b0;
        send(16'hfffe, 1'b1);
        check("t2_sum", {16'd0, out_sum}, 32'hfffe);
        check("t2_carries", {24'd0, out_carries}, 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {16'd0, out_sum}, 32'hfffe);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_sum", {16'd0, out_sum}, 32'h1234);
        check("bp_next_carries", {24'd0, out_carries}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // aaaa + 5555 + 0001 wraps to 0000
        send(16'haaaa, 1'b0);
        send(16'h5555, 1'b0);
        send(16'h0001, 1'b1);
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        check("t3_sum", {16'd0, out_sum}, 32'h0000);
        check("t3_carries", {24'd0, out_carries}, 32'd1);
        @(negedge clk);

        // Five ffff beats: four carries, saturating at 3 in the CNT_W=2 copy
        for (int i = 0; i < 5; i++) send(16'hffff, (i == 4));
        check("t4_sum", {16'd0, out_sum}, 32'hfffb);
        check("t4_carries", {24'd0, out_carries}, 32'd4);
        check("t4_valid_w2", {31'd0, out_valid2}, 32'd1);
        check("t4_sum_w2", {16'd0, out_sum2}, 32'hfffb);
        check("t4_carries_sat_w2", {30'd0, out_carries2}, 32'd3);
        @(negedge clk);

        // Partial packet discarded by an asynchronous mid-cycle reset
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_in_ready", {31'd0, in_ready}, 32'd0);
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_out_sum", {16'd0, out_sum}, 32'd0);
        check("ar_out_carries", {24'd0, out_carries}, 32'd0);
        check("ar_out_sum_w2", {16'd0, out_sum2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ar_in_ready_held", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("ar_in_ready_up", {31'd0, in_ready}, 32'd1);
        check("ar_in_ready_up_w2", {31'd0, in_ready2}, 32'd1);
        send(16'h0005, 1'b1);
        check("ar_valid", {31'd0, out_valid}, 32'd1);
        check("ar_sum", {16'd0, out_sum}, 32'h0005);
        check("ar_carries", {24'd0, out_carries}, 32'd0);
        @(negedge clk);
        check("ar_done", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
